// File: rtl/key_spi_tx.sv
// Key-change event queue served one byte per frame over a mode-0 SPI slave; optional auto-repeat via KEY_SPI_REPEAT_EN.
// Latency: a key change is queued 2 clk after the pin; SPI strobes act 3 clk after the sck/cs_n pin edge.
// Backpressure: none toward the key source; a push into a full FIFO without a pop is dropped and sets sticky overflow.
module key_spi_tx #(
    parameter int          DEPTH         = 4,
    parameter logic [23:0] REPEAT_CYCLES = 24'd4000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               key_pressed,
    input  logic                     sck,
    input  logic                     cs_n,
    output logic                     sdo,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [3:0]    cur_key_q, prev_key_q;
    logic          sck_s1_q, sck_s2_q, sck_h_q;
    logic          cs_s1_q, cs_s2_q, cs_h_q;
    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    state_t        state_q;
    logic [7:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic          sdo_q, valid_q, sent_ovf_q;

    logic sck_rise, sck_fall, cs_fall;
    logic change, rep_push, push, pop, clr_ovf, full, empty, wr_en, drop;
    logic [7:0] frame_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_key_q  <= 4'd0;
            prev_key_q <= 4'd0;
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_h_q    <= 1'b0;
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_h_q     <= 1'b1;
        end else begin
            cur_key_q  <= key_pressed;
            prev_key_q <= cur_key_q;
            sck_s1_q   <= sck;
            sck_s2_q   <= sck_s1_q;
            sck_h_q    <= sck_s2_q;
            cs_s1_q    <= cs_n;
            cs_s2_q    <= cs_s1_q;
            cs_h_q     <= cs_s2_q;
        end
    end

    assign sck_rise = sck_s2_q & ~sck_h_q;
    assign sck_fall = ~sck_s2_q & sck_h_q;
    assign cs_fall  = ~cs_s2_q & cs_h_q;
    assign change   = (cur_key_q != prev_key_q);

`ifdef KEY_SPI_REPEAT_EN
    logic [23:0] hold_q;

    // Repeat fires every REPEAT_CYCLES clk of an unchanged non-zero key, counted from the change.
    assign rep_push = !change && (cur_key_q != 4'd0) && (hold_q == REPEAT_CYCLES - 24'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= 24'd0;
        end else if (change || rep_push) begin
            hold_q <= 24'd0;
        end else if (cur_key_q != 4'd0) begin
            hold_q <= hold_q + 24'd1;
        end
    end
`else
    assign rep_push = 1'b0 & (REPEAT_CYCLES != 24'd0);
`endif

    assign push       = change | rep_push;
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign pop        = (state_q == DONE) && (bit_cnt_q == 4'd8) && valid_q;
    assign clr_ovf    = (state_q == DONE) && (bit_cnt_q == 4'd8) && sent_ovf_q;
    assign wr_en      = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign frame_byte = {!empty, overflow_q, 2'b00, empty ? 4'h0 : mem_q[rd_ptr_q]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= cur_key_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + (AW)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW)'(1);
            end
            if (wr_en && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop && !wr_en) begin
                count_q <= count_q - (AW+1)'(1);
            end
            // A fresh drop outranks the clear of an older reported one.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 4'd0;
            sdo_q      <= 1'b0;
            valid_q    <= 1'b0;
            sent_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sdo_q <= 1'b0;
                    if (cs_fall) begin
                        shift_q    <= frame_byte;
                        sdo_q      <= frame_byte[7];
                        bit_cnt_q  <= 4'd0;
                        valid_q    <= !empty;
                        sent_ovf_q <= overflow_q;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_s2_q) begin
                        sdo_q   <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        if (sck_rise && bit_cnt_q != 4'd8) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                        // Past the eighth bit the register drains to zero and sdo stays low.
                        if (sck_fall) begin
                            if (bit_cnt_q < 4'd8) begin
                                shift_q <= {shift_q[6:0], 1'b0};
                                sdo_q   <= shift_q[6];
                            end else begin
                                shift_q <= 8'h00;
                                sdo_q   <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    sdo_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    sdo_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sdo        = sdo_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_spi_tx.sv
// Directed bench for key_spi_tx: reset, change events, overflow, abort, push/pop collision, optional repeat.
// Inputs are driven and outputs sampled 1 ns after the rising clk edge.
module tb_key_spi_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_pressed;
    logic       sck;
    logic       cs_n;
    logic       sdo;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] rx;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    key_spi_tx #(.DEPTH(4), .REPEAT_CYCLES(24'd16)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_pressed(key_pressed),
        .sck        (sck),
        .cs_n       (cs_n),
        .sdo        (sdo),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MCU side: nbits sck pulses, sdo sampled just before each rise; optional key change
    // timed so its push lands on the DONE (pop) cycle of this frame.
    task automatic spi_frame(input int nbits, input int key_end, output logic [7:0] r);
        r    = 8'h00;
        cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            r   = {r[6:0], sdo};
            sck = 1'b1;
            tick(5);
            sck = 1'b0;
            tick(5);
        end
        tick(2);
        cs_n = 1'b1;
        if (key_end >= 0) begin
            tick(2);
            key_pressed = 4'(key_end);
        end
        tick(10);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp);
        logic [7:0] r;
        spi_frame(8, -1, r);
        check(tag, {24'd0, r}, {24'd0, exp});
    endtask

    initial begin
        int seq6 [6] = '{1, 2, 3, 4, 1, 2};
        int seq4 [4] = '{1, 2, 1, 2};
        reset = 1'b0; key_pressed = 4'd0; sck = 1'b0; cs_n = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(3);
        check("rst_sdo", 32'(sdo), 32'd0);
        check("rst_cnt", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        expect_frame("empty_frame", 8'h00);

        key_pressed = 4'd5; tick(4);
        check("cnt_press", 32'(fifo_count), 32'd1);
        key_pressed = 4'd0; tick(4);
        check("cnt_release", 32'(fifo_count), 32'd2);
        expect_frame("frame_85", 8'h85);
        expect_frame("frame_80", 8'h80);
        expect_frame("frame_00", 8'h00);
        check("cnt_drained", 32'(fifo_count), 32'd0);

        foreach (seq6[i]) begin
            key_pressed = 4'(seq6[i]);
            tick(3);
        end
        check("ovf_cnt", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        expect_frame("frame_C1", 8'hC1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        expect_frame("frame_82", 8'h82);
        expect_frame("frame_83", 8'h83);
        expect_frame("frame_84", 8'h84);

        key_pressed = 4'd7; tick(4);
        check("abort_pre_cnt", 32'(fifo_count), 32'd1);
        spi_frame(3, -1, rx);
        check("abort_bits", 32'(rx), 32'h4);
        check("abort_cnt", 32'(fifo_count), 32'd1);
        expect_frame("frame_87", 8'h87);
        check("abort_popped", 32'(fifo_count), 32'd0);

        foreach (seq4[i]) begin
            key_pressed = 4'(seq4[i]);
            tick(3);
        end
        check("sim_full", 32'(fifo_count), 32'd4);
        spi_frame(8, 3, rx);
        check("sim_frame", 32'(rx), 32'h81);
        check("sim_cnt", 32'(fifo_count), 32'd4);
        check("sim_ovf", 32'(overflow), 32'd0);
        expect_frame("sim_82", 8'h82);
        expect_frame("sim_81", 8'h81);
        expect_frame("sim_82b", 8'h82);
        expect_frame("sim_83_last", 8'h83);
        expect_frame("sim_empty", 8'h00);

`ifdef KEY_SPI_REPEAT_EN
        key_pressed = 4'd6;
        tick(50);
        check("rep_cnt", 32'(fifo_count), 32'd4);
        key_pressed = 4'd0;
        tick(40);
        check("rep_rel_cnt", 32'(fifo_count), 32'd4);
        check("rep_rel_ovf", 32'(overflow), 32'd1);
        expect_frame("rep_C6", 8'hC6);
        expect_frame("rep_86a", 8'h86);
        expect_frame("rep_86b", 8'h86);
        expect_frame("rep_86c", 8'h86);
        expect_frame("rep_no_zero_repeat", 8'h00);
`endif

        key_pressed = 4'd4; tick(4);
        check("mid_pre_cnt", 32'(fifo_count), 32'd1);
        cs_n = 1'b0;
        tick(6);
        sck = 1'b1; tick(5);
        sck = 1'b0; tick(3);
        reset = 1'b0; key_pressed = 4'd0; cs_n = 1'b1; sck = 1'b0;
        tick(2);
        check("mid_rst_sdo", 32'(sdo), 32'd0);
        check("mid_rst_cnt", 32'(fifo_count), 32'd0);
        reset = 1'b1;
        tick(6);
        check("post_rst_cnt", 32'(fifo_count), 32'd0);
        check("post_rst_ovf", 32'(overflow), 32'd0);
        expect_frame("post_rst_frame", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
